// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
// Round-robin arbiter that shares one VGA pixel port among N pixel-drawing
// requesters. Each grant produces a one-cycle plot pulse followed by at least
// GAP idle cycles, so a downstream VGA monitor never misses a pixel.
//
// Ports
//   CLOCK_50   in   1      system clock, rising edge
//   Resetn     in   1      asynchronous active-low reset
//   req        in   N      per-requester pixel request, held until ack
//   req_x      in   10*N   requester i column at [10*i +: 10]
//   req_y      in   9*N    requester i row at [9*i +: 9]
//   req_color  in   3*N    requester i colour at [3*i +: 3]
//   ack        out  N      one-hot grant pulse, coincident with plot
//   VGA_X      out  10     registered column of the current pixel
//   VGA_Y      out  9      registered row
//   VGA_COLOR  out  3      registered colour
//   plot       out  1      one-cycle pixel strobe
//   busy       out  1      high whenever the arbiter is not idle
`timescale 1ns/1ps

module vga_plot_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned GAP = 2
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic [N-1:0]      req,
  input  logic [10*N-1:0]   req_x,
  input  logic [9*N-1:0]    req_y,
  input  logic [3*N-1:0]    req_color,
  output logic [N-1:0]      ack,
  output logic [9:0]        VGA_X,
  output logic [8:0]        VGA_Y,
  output logic [2:0]        VGA_COLOR,
  output logic              plot,
  output logic              busy
);

  localparam int unsigned PTR_W    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLOT = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] color;
  } pixel_t;

  // Reject out-of-range parameterisations at elaboration time.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("vga_plot_arbiter: N must be in 2..8");
  end
  if (GAP > 15) begin : g_bad_gap
    $error("vga_plot_arbiter: GAP must be in 0..15");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [PTR_W-1:0]   last_q,  last_d;
  pixel_t             pix_q,   pix_d;
  logic [N-1:0]       ack_q,   ack_d;
  logic               plot_q,  plot_d;
  logic               busy_q,  busy_d;

  logic               found_c;
  logic [PTR_W-1:0]   win_c;
  pixel_t             sel_c;

  // Round-robin pick: search last+1, last+2, ... (mod N); first hit wins.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found_c && req[i] && (((32'(last_q) + off) % N) == i)) begin
          found_c = 1'b1;
          win_c   = PTR_W'(i);
        end
      end
    end
  end

  // Gather the winner's pixel slices.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_c == PTR_W'(i)) begin
        sel_c.x     = req_x[10*i +: 10];
        sel_c.y     = req_y[9*i +: 9];
        sel_c.color = req_color[3*i +: 3];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    pix_d   = pix_q;
    ack_d   = '0;
    plot_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          pix_d   = sel_c;
          ack_d   = {{(N-1){1'b0}}, 1'b1} << win_c;
          plot_d  = 1'b1;
          last_d  = win_c;
          state_d = S_PLOT;
        end
      end
      S_PLOT: begin
        if (GAP == 0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CNT_W'(GAP_LOAD);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Requests are deliberately ignored here; they wait for IDLE.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears outputs immediately.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= PTR_W'(N - 1);
      pix_q   <= '0;
      ack_q   <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      pix_q   <= pix_d;
      ack_q   <= ack_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign VGA_X     = pix_q.x;
  assign VGA_Y     = pix_q.y;
  assign VGA_COLOR = pix_q.color;
  assign plot      = plot_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Testbench for vga_plot_arbiter: two instances (GAP=2 and GAP=0) fed by
// queue-driven requester models; expected grants go into scoreboards that
// monitors pop whenever plot is seen.
`timescale 1ns/1ps

module tb_vga_plot_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned GAP_A = 2;
  localparam int unsigned GAP_B = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct packed {
    logic [N-1:0] ack;
    logic [9:0]   x;
    logic [8:0]   y;
    logic [2:0]   c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Instance A (GAP=2)
  logic            rst_a;
  logic [N-1:0]    req_a;
  logic [10*N-1:0] rx_a;
  logic [9*N-1:0]  ry_a;
  logic [3*N-1:0]  rc_a;
  logic [N-1:0]    ack_a;
  logic [9:0]      vx_a;
  logic [8:0]      vy_a;
  logic [2:0]      vc_a;
  logic            plot_a, busy_a;

  // Instance B (GAP=0)
  logic            rst_b;
  logic [N-1:0]    req_b;
  logic [10*N-1:0] rx_b;
  logic [9*N-1:0]  ry_b;
  logic [3*N-1:0]  rc_b;
  logic [N-1:0]    ack_b;
  logic [9:0]      vx_b;
  logic [8:0]      vy_b;
  logic [2:0]      vc_b;
  logic            plot_b, busy_b;

  vga_plot_arbiter #(.N(N), .GAP(GAP_A)) u_dut_a (
    .CLOCK_50(clk), .Resetn(rst_a), .req(req_a), .req_x(rx_a), .req_y(ry_a),
    .req_color(rc_a), .ack(ack_a), .VGA_X(vx_a), .VGA_Y(vy_a),
    .VGA_COLOR(vc_a), .plot(plot_a), .busy(busy_a)
  );

  vga_plot_arbiter #(.N(N), .GAP(GAP_B)) u_dut_b (
    .CLOCK_50(clk), .Resetn(rst_b), .req(req_b), .req_x(rx_b), .req_y(ry_b),
    .req_color(rc_b), .ack(ack_b), .VGA_X(vx_b), .VGA_Y(vy_b),
    .VGA_COLOR(vc_b), .plot(plot_b), .busy(busy_b)
  );

  pix_t pq_a[N][$];
  pix_t pq_b[N][$];
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   pc_a[$];
  int   pc_b[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic give(bit sel, int i, int x, int y, int c);
    pix_t p;
    p.x = 10'(x);
    p.y = 9'(y);
    p.c = 3'(c);
    if (sel) pq_b[i].push_back(p);
    else     pq_a[i].push_back(p);
  endtask

  task automatic expect_grant(bit sel, int a, int x, int y, int c);
    exp_t e;
    e.ack = N'(a);
    e.x   = 10'(x);
    e.y   = 9'(y);
    e.c   = 3'(c);
    if (sel) sb_b.push_back(e);
    else     sb_a.push_back(e);
  endtask

  function automatic bit pending(bit sel);
    bit p;
    p = sel ? (sb_b.size() != 0) : (sb_a.size() != 0);
    for (int i = 0; i < N; i++) begin
      if (sel ? (pq_b[i].size() != 0) : (pq_a[i].size() != 0)) p = 1'b1;
    end
    return p;
  endfunction

  // Bounded wait for all expected grants, then let the FSM settle back to IDLE.
  task automatic drain(bit sel, string name, int budget);
    int n;
    n = 0;
    while (pending(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pending(sel)) begin
      errors++;
      $display("FAIL %s: timeout, %0d grants still expected", name,
               sel ? sb_b.size() : sb_a.size());
      if (sel) sb_b.delete();
      else     sb_a.delete();
      for (int i = 0; i < N; i++) begin
        if (sel) pq_b[i].delete();
        else     pq_a[i].delete();
      end
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  // Bounded wait for a plot pulse on instance A; returns at negedge+1.
  task automatic wait_plot_a(string name, int budget);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (plot_a) ok = 1'b1;
    end
    chk(name, 32'(ok), 32'(1));
    #1;
  endtask

  // Requester models: present queue head, pop on the ack cycle.
  initial begin
    req_a = '0; rx_a = '0; ry_a = '0; rc_a = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack_a[i] && pq_a[i].size() != 0) void'(pq_a[i].pop_front());
        if (pq_a[i].size() != 0) begin
          req_a[i]          = 1'b1;
          rx_a[10*i +: 10]  = pq_a[i][0].x;
          ry_a[9*i +: 9]    = pq_a[i][0].y;
          rc_a[3*i +: 3]    = pq_a[i][0].c;
        end else begin
          req_a[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    req_b = '0; rx_b = '0; ry_b = '0; rc_b = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack_b[i] && pq_b[i].size() != 0) void'(pq_b[i].pop_front());
        if (pq_b[i].size() != 0) begin
          req_b[i]          = 1'b1;
          rx_b[10*i +: 10]  = pq_b[i][0].x;
          ry_b[9*i +: 9]    = pq_b[i][0].y;
          rc_b[3*i +: 3]    = pq_b[i][0].c;
        end else begin
          req_b[i] = 1'b0;
        end
      end
    end
  end

  // Monitor A: scoreboard compare on plot, spacing and ack-only-with-plot.
  initial begin
    bit   prev;
    int   last;
    exp_t e;
    prev = 1'b0;
    last = -1;
    forever begin
      @(negedge clk);
      if (!rst_a) begin
        prev = 1'b0;
        last = -1;
      end else begin
        if (plot_a) begin
          chk("busy_with_plot_a", 32'(busy_a), 32'(1));
          chk("no_back_to_back_a", 32'(prev), 32'(0));
          if (last >= 0) chk("min_spacing_a", 32'((cyc - last) >= int'(2 + GAP_A)), 32'(1));
          checks++;
          if (sb_a.size() == 0) begin
            errors++;
            $display("FAIL unexpected_plot_a: ack=%b x=%0d y=%0d c=%0d", ack_a, vx_a, vy_a, vc_a);
          end else begin
            e = sb_a.pop_front();
            if (ack_a !== e.ack || vx_a !== e.x || vy_a !== e.y || vc_a !== e.c) begin
              errors++;
              $display("FAIL grant_a: got ack=%b x=%0d y=%0d c=%0d expected ack=%b x=%0d y=%0d c=%0d",
                       ack_a, vx_a, vy_a, vc_a, e.ack, e.x, e.y, e.c);
            end
          end
          last = cyc;
          pc_a.push_back(cyc);
        end else begin
          chk("ack_without_plot_a", 32'(ack_a), 32'(0));
        end
        prev = plot_a;
      end
    end
  end

  // Monitor B: same checks for the GAP=0 instance.
  initial begin
    bit   prev;
    int   last;
    exp_t e;
    prev = 1'b0;
    last = -1;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        prev = 1'b0;
        last = -1;
      end else begin
        if (plot_b) begin
          chk("no_back_to_back_b", 32'(prev), 32'(0));
          if (last >= 0) chk("min_spacing_b", 32'((cyc - last) >= int'(2 + GAP_B)), 32'(1));
          checks++;
          if (sb_b.size() == 0) begin
            errors++;
            $display("FAIL unexpected_plot_b: ack=%b x=%0d", ack_b, vx_b);
          end else begin
            e = sb_b.pop_front();
            if (ack_b !== e.ack || vx_b !== e.x || vy_b !== e.y || vc_b !== e.c) begin
              errors++;
              $display("FAIL grant_b: got ack=%b x=%0d y=%0d c=%0d expected ack=%b x=%0d y=%0d c=%0d",
                       ack_b, vx_b, vy_b, vc_b, e.ack, e.x, e.y, e.c);
            end
          end
          last = cyc;
          pc_b.push_back(cyc);
        end else begin
          chk("ack_without_plot_b", 32'(ack_b), 32'(0));
        end
        prev = plot_b;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int rel;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset with all four requesting, then rotation from requester 0
    give(0, 0, 5, 7, 3);   give(0, 0, 50, 70, 1);
    give(0, 1, 11, 21, 2); give(0, 2, 12, 22, 4); give(0, 3, 13, 23, 5);
    expect_grant(0, 4'b0001, 5, 7, 3);
    expect_grant(0, 4'b0010, 11, 21, 2);
    expect_grant(0, 4'b0100, 12, 22, 4);
    expect_grant(0, 4'b1000, 13, 23, 5);
    expect_grant(0, 4'b0001, 50, 70, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_plot", 32'(plot_a), 32'(0));
    chk("rst_ack", 32'(ack_a), 32'(0));
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_vga_x", 32'(vx_a), 32'(0));
    chk("rst_vga_y", 32'(vy_a), 32'(0));
    chk("rst_vga_color", 32'(vc_a), 32'(0));
    pc_a.delete();
    rel   = cyc;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drain(0, "rotation", 80);
    chk("rotation_count", 32'(pc_a.size()), 32'(5));
    if (pc_a.size() > 0) chk("first_grant_latency", 32'(pc_a[0] - rel), 32'(1));
    for (int k = 1; k < pc_a.size(); k++) chk("rotation_spacing", 32'(pc_a[k] - pc_a[k-1]), 32'(4));

    // Sparse: requesters 2 and 0 alternate once last=2
    give(0, 2, 200, 100, 6); give(0, 2, 201, 101, 6); give(0, 2, 202, 102, 6);
    give(0, 0, 300, 200, 7); give(0, 0, 301, 201, 7);
    expect_grant(0, 4'b0100, 200, 100, 6);
    expect_grant(0, 4'b0001, 300, 200, 7);
    expect_grant(0, 4'b0100, 201, 101, 6);
    expect_grant(0, 4'b0001, 301, 201, 7);
    expect_grant(0, 4'b0100, 202, 102, 6);
    drain(0, "sparse", 80);

    // Late arrival: requester 3 appears during the gap after a grant to 1
    pc_a.delete();
    give(0, 1, 400, 300, 1);
    expect_grant(0, 4'b0010, 400, 300, 1);
    wait_plot_a("late_first_plot", 20);
    give(0, 3, 401, 301, 2);
    expect_grant(0, 4'b1000, 401, 301, 2);
    drain(0, "late", 40);
    chk("late_count", 32'(pc_a.size()), 32'(2));
    if (pc_a.size() == 2) chk("late_spacing", 32'(pc_a[1] - pc_a[0]), 32'(4));

    // Reset during PLOT clears outputs before the next edge
    give(0, 2, 500, 400, 3);
    expect_grant(0, 4'b0100, 500, 400, 3);
    wait_plot_a("midplot_plot", 20);
    rst_a = 1'b0;
    #1;
    chk("midplot_rst_plot", 32'(plot_a), 32'(0));
    chk("midplot_rst_ack", 32'(ack_a), 32'(0));
    chk("midplot_rst_busy", 32'(busy_a), 32'(0));
    chk("midplot_rst_vga_x", 32'(vx_a), 32'(0));
    @(negedge clk);
    #1;
    rst_a = 1'b1;

    // Reset during GAP, then the pointer restarts at requester 0
    give(0, 0, 600, 450, 4);
    expect_grant(0, 4'b0001, 600, 450, 4);
    wait_plot_a("midgap_plot", 20);
    @(negedge clk);
    #1;
    chk("midgap_busy", 32'(busy_a), 32'(1));
    chk("midgap_no_plot", 32'(plot_a), 32'(0));
    rst_a = 1'b0;
    #1;
    chk("midgap_rst_busy", 32'(busy_a), 32'(0));
    @(negedge clk);
    #1;
    rst_a = 1'b1;
    give(0, 1, 700, 460, 5);
    give(0, 0, 701, 461, 6);
    expect_grant(0, 4'b0001, 701, 461, 6);
    expect_grant(0, 4'b0010, 700, 460, 5);
    drain(0, "pointer_restart", 40);

    // GAP=0 streaming on instance B
    pc_b.delete();
    for (int k = 0; k < 10; k++) begin
      give(1, 0, k, 20, 2);
      expect_grant(1, 4'b0001, k, 20, 2);
    end
    drain(1, "stream", 100);
    chk("stream_count", 32'(pc_b.size()), 32'(10));
    for (int k = 1; k < pc_b.size(); k++) chk("stream_spacing", 32'(pc_b[k] - pc_b[k-1]), 32'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Round-robin arbiter that shares the single simulated VGA pixel port (VGA_X, VGA_Y, VGA_COLOR, plot) among N independent pixel-drawing requesters. It sits between the design's drawing engines and the board-level VGA pins of `top`. It serialises their pixel writes into one-cycle plot pulses with a guaranteed idle gap, so that the simulator's VGA monitor captures every pixel.

## Interface
- N, 4: number of requesters; 2..8.
- GAP, 2: minimum idle cycles between consecutive plot pulses; 0..15.
- CLOCK_50  in  1: system clock; all logic rising-edge.
- Resetn  in  1: asynchronous, active-low reset (driven from KEY[0] at top level).
- req  in  N: req[i] high requests one pixel write for requester i; held until ack[i].
- req_x  in  10*N: requester i column at [10*i +: 10].
- req_y  in  9*N: requester i row at [9*i +: 9].
- req_color  in  3*N: requester i colour at [3*i +: 3].
- ack  out  N: one-hot, one-cycle grant/completion pulse, coincident with plot.
- VGA_X  out  10: registered column of the current pixel.
- VGA_Y  out  9: registered row.
- VGA_COLOR  out  3: registered colour.
- plot  out  1: one-cycle pixel strobe.
- busy  out  1: high in any state other than IDLE.

## Operation
- Reset values: VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, ack=0, busy=0, state=IDLE, gap counter=0, last-grant pointer=N-1.
- FSM states:
  - IDLE. If req==0, stay. Otherwise choose the winner w, the first index with req set in the order last+1, last+2, …, mod N. Latch req_x/req_y/req_color slices of w into VGA_X/VGA_Y/VGA_COLOR. Set plot=1, ack=1<<w, last=w. Go to PLOT.
  - PLOT (one cycle): clear plot and ack. If GAP==0, go to IDLE. Otherwise load counter with GAP-1 and go to GAP.
  - GAP: ignore req. Decrement the counter; when it is 0, go to IDLE.
- VGA_X/Y/COLOR hold their last value outside PLOT; they are never cleared except by reset.
- Requester contract:
  - req and data stay stable until ack[i] is seen.
  - On the edge ending the ack cycle, the requester either drops req or presents the next pixel with req held.
  - The arbiter never samples req in PLOT or GAP.
- Fairness: a continuously requesting set of k requesters is granted in strict rotation, each once per k grants. No requester waits more than N-1 grants.
- Requests arriving during PLOT/GAP are not lost; they are evaluated in the next IDLE cycle.
- Reset asserted mid-operation clears every output immediately, asynchronously. An in-flight pixel whose ack was not yet given is dropped; its requester still holds req and is served after reset.
- Widths: all coordinates pass through unmodified. No range clamping; 640x480 bounds are the requester's responsibility.

## Timing
- Latency: req[i] high at edge k in IDLE, uncontended → plot and ack[i] high during cycle k..k+1.
- Throughput: one pixel per 2+GAP cycles.
  - GAP=2: plot pulses at most every 4 cycles.
  - GAP=0: every 2 cycles.
- plot is high for exactly one clock per grant, and never on two consecutive cycles.
- busy = (state != IDLE). It goes high in the same cycle as plot and low on entering IDLE.
- ack, plot and the VGA outputs all change on the same edge (all registered, no combinational paths from req).

## Test plan
- Reset: Resetn=0 with req=4'b1111 → all outputs 0. Release, with requester 0 holding x=5, y=7, color=3 → on the first IDLE edge, plot=1, ack=4'b0001, VGA_X=5, VGA_Y=7, VGA_COLOR=3.
- Rotation: N=4, GAP=2, all four req held continuously → ack sequence 0001, 0010, 0100, 1000, 0001; plot pulses exactly 4 cycles apart.
- Sparse: only req[2] and req[0] held after last=2 → grants alternate 0, 2, 0, 2; no ack on idle requesters.
- Late arrival: req[3] raised during the GAP of a grant to requester 1 → req[3] granted in the first IDLE cycle after the gap; no pulse inside the gap.
- GAP=0, single requester streaming x=0..9 → ten plot pulses 2 cycles apart with VGA_X=0..9 in order, none dropped or duplicated.
- Reset mid-GAP and mid-PLOT → plot, ack and busy fall asynchronously before the next edge. After release, the pointer restarts at requester 0.
